bsg_nasti_mem_responder: RTL

NASTI slave endpoint that terminates the master-side ar/aw/w channels produced by the NASTI interconnect and answers them with r/b responses from an internal flop-array memory. It sits at the far end of the NASTI link and is the memory model used behind the interconnect in tile-level integration and simulation. It serves one transaction at a time, supports multi-beat FIXED/INCR bursts and byte strobes, and flags out-of-range accesses.

---
 rtl/bsg_nasti_mem_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/bsg_nasti_mem_responder.sv
// NASTI slave endpoint backed by a flop-array memory; serves one burst at a time.
// Packets are flat: a = {id, addr[31:0], len[7:0], burst[1:0]}, w = {data[63:0], strb[7:0], last},
// b = {id, resp[1:0]}, r = {id, data[63:0], resp[1:0], last}.
module bsg_nasti_mem_responder #(
    parameter int unsigned els_p       = 1024,
    parameter logic [31:0] base_addr_p = 32'h8000_0000,
    parameter int unsigned id_width_p  = 6
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,

    input  logic                   nasti_ar_valid_i,
    input  logic [id_width_p+41:0] nasti_ar_data_i,
    output logic                   nasti_ar_ready_o,

    input  logic                   nasti_aw_valid_i,
    input  logic [id_width_p+41:0] nasti_aw_data_i,
    output logic                   nasti_aw_ready_o,

    input  logic                   nasti_w_valid_i,
    input  logic [72:0]            nasti_w_data_i,
    output logic                   nasti_w_ready_o,

    output logic                   nasti_b_valid_o,
    output logic [id_width_p+1:0]  nasti_b_data_o,
    input  logic                   nasti_b_ready_i,

    output logic                   nasti_r_valid_o,
    output logic [id_width_p+66:0] nasti_r_data_o,
    input  logic                   nasti_r_ready_i
);

    localparam int unsigned idx_w_lp = $clog2(els_p);
    localparam logic [32:0] span_lp  = {1'b0, 32'(els_p)} << 3;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StWresp} state_e;

    state_e                  state_q, state_d;
    logic                    rd_prio_q;
    logic [7:0]              beat_q;
    logic [id_width_p-1:0]   id_q;
    logic [31:0]             addr_q;
    logic [7:0]              len_q;
    logic [1:0]              burst_q;
    logic                    decerr_q, slverr_q;
    logic                    r_valid_q, b_valid_q;
    logic [id_width_p+66:0]  r_data_q;
    logic [id_width_p+1:0]   b_data_q;
    logic [63:0]             mem [els_p];

    logic                    ar_hs, aw_hs, r_hs, w_hs, b_hs, last_beat, last_mismatch;
    logic [id_width_p+41:0]  req;
    logic [31:0]             req_addr, next_addr;
    logic                    req_decerr;

    function automatic logic [idx_w_lp-1:0] word_idx(input logic [31:0] a);
        return idx_w_lp'((a - base_addr_p) >> 3);
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, base_addr_p};
        return !off[32] && (off < span_lp);
    endfunction

    assign ar_hs         = nasti_ar_valid_i & nasti_ar_ready_o;
    assign aw_hs         = nasti_aw_valid_i & nasti_aw_ready_o;
    assign w_hs          = nasti_w_valid_i & nasti_w_ready_o;
    assign r_hs          = r_valid_q & nasti_r_ready_i;
    assign b_hs          = b_valid_q & nasti_b_ready_i;
    assign last_beat     = (beat_q == len_q);
    assign last_mismatch = nasti_w_data_i[0] != last_beat;
    assign req           = ar_hs ? nasti_ar_data_i : nasti_aw_data_i;
    assign req_addr      = req[41:10];
    assign req_decerr    = !in_range(req_addr);
    // WRAP is served as INCR; only FIXED holds the address
    assign next_addr     = (burst_q == 2'b00) ? addr_q : addr_q + 32'd8;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    state_d = StRead;
                end else if (aw_hs) begin
                    state_d = StWrite;
                end
            end
            StRead:  if (r_hs && last_beat) state_d = StIdle;
            StWrite: if (w_hs && last_beat) state_d = StWresp;
            StWresp: if (b_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        nasti_ar_ready_o = 1'b0;
        nasti_aw_ready_o = 1'b0;
        if (reset_n_i && state_q == StIdle) begin
            nasti_ar_ready_o = nasti_ar_valid_i & (~nasti_aw_valid_i | rd_prio_q);
            nasti_aw_ready_o = nasti_aw_valid_i & (~nasti_ar_valid_i | ~rd_prio_q);
        end
        nasti_w_ready_o = (state_q == StWrite);
        nasti_r_valid_o = r_valid_q;
        nasti_r_data_o  = r_data_q;
        nasti_b_valid_o = b_valid_q;
        nasti_b_data_o  = b_data_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_prio_q <= 1'b1;
            beat_q    <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            decerr_q  <= 1'b0;
            slverr_q  <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
        end else begin
            if (state_q == StIdle && nasti_ar_valid_i && nasti_aw_valid_i) begin
                rd_prio_q <= ~rd_prio_q;
            end
            if (ar_hs || aw_hs) begin
                id_q     <= req[id_width_p+41:42];
                addr_q   <= req_addr;
                len_q    <= req[9:2];
                burst_q  <= req[1:0];
                decerr_q <= req_decerr;
                slverr_q <= 1'b0;
                beat_q   <= '0;
            end
            if (ar_hs) begin
                r_valid_q <= 1'b1;
                r_data_q  <= {req[id_width_p+41:42],
                              req_decerr ? 64'd0 : mem[word_idx(req_addr)],
                              req_decerr ? 2'b11 : 2'b00,
                              req[9:2] == 8'd0};
            end else if (r_hs) begin
                if (last_beat) begin
                    r_valid_q <= 1'b0;
                end else begin
                    beat_q   <= beat_q + 8'd1;
                    addr_q   <= next_addr;
                    r_data_q <= {id_q,
                                 decerr_q ? 64'd0 : mem[word_idx(next_addr)],
                                 decerr_q ? 2'b11 : 2'b00,
                                 (beat_q + 8'd1) == len_q};
                end
            end
            if (w_hs) begin
                if (last_beat) begin
                    b_valid_q <= 1'b1;
                    b_data_q  <= {id_q, decerr_q ? 2'b11 :
                                        (slverr_q | last_mismatch) ? 2'b10 : 2'b00};
                end else begin
                    beat_q   <= beat_q + 8'd1;
                    addr_q   <= next_addr;
                    slverr_q <= slverr_q | last_mismatch;
                end
            end
            if (b_hs) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    // Memory contents survive reset
    always_ff @(posedge clk_i) begin
        if (w_hs && !decerr_q) begin
            for (int i = 0; i < 8; i++) begin
                if (nasti_w_data_i[1+i]) begin
                    mem[word_idx(addr_q)][8*i +: 8] <= nasti_w_data_i[9+8*i +: 8];
                end
            end
        end
    end

endmodule
